// File: rtl/program_loader_if.sv
// Instruction-memory write port and loader status bundle.
// Driven by program_loader, consumed by the datapath's IMEM and PC logic.
interface program_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        run;
  logic        error;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    output busy, run, error
  );

  modport slave (
    input imem_we, imem_addr, imem_wdata,
    input busy, run, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: 16x-oversampled 8N1 UART feeding a word-count-prefixed image into IMEM.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int BAUD_DIV = 27,
  parameter int ADDR_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  program_loader_if.master bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {CNT_HI, CNT_LO, WORD, CHK, DONE, ERROR} st_t;

`ifdef LOADER_CHECKSUM_EN
  localparam st_t W_END = CHK;
`else
  localparam st_t W_END = DONE;
`endif

  logic        r_rx_s1, r_rx_s2;
  rx_t         r_rx_st;
  logic [15:0] r_div;
  logic [3:0]  r_tcnt;
  logic [2:0]  r_bcnt;
  logic [7:0]  r_sh;
  logic        r_bv, r_ferr;
  wire         w_tick = (r_div == 16'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_st <= RX_IDLE;
      r_div   <= '0;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_sh    <= '0;
      r_bv    <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_bv   <= 1'b0;
      r_ferr <= 1'b0;
      r_div  <= (w_tick || r_rx_st == RX_IDLE) ? '0 : r_div + 16'd1;
      unique case (r_rx_st)
        RX_IDLE: if (!r_rx_s2) begin
          r_rx_st <= RX_START;
          r_tcnt  <= '0;
        end
        RX_START: if (w_tick) begin
          if (r_tcnt == 4'd7) begin
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_rx_st <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        RX_DATA: if (w_tick) begin
          if (r_tcnt == 4'd15) begin
            r_tcnt <= '0;
            r_sh   <= {r_rx_s2, r_sh[7:1]};
            r_bcnt <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) r_rx_st <= RX_STOP;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        RX_STOP: if (w_tick) begin
          if (r_tcnt == 4'd15) begin
            r_tcnt  <= '0;
            r_bv    <= r_rx_s2;
            r_ferr  <= !r_rx_s2;
            r_rx_st <= RX_IDLE;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  st_t         r_st, w_nst;
  logic [15:0] r_n;
  logic [ADDR_W:0] r_widx;
  logic [1:0]  r_bidx;
  logic [31:0] r_asm, r_wdata, r_addr;
  logic        r_we;
  wire  [7:0]  w_byte  = r_sh;
  wire  [15:0] w_n_new = {r_n[15:8], w_byte};
  wire  [16:0] w_max   = 17'd1 << ADDR_W;
  wire         w_live  = (r_st != DONE) && (r_st != ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= CNT_HI;
    else       r_st <= w_nst;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
`endif

  always_comb begin
    w_nst = r_st;
    if (r_ferr && w_live) w_nst = ERROR;
    else begin
      unique case (r_st)
        CNT_HI: if (r_bv) w_nst = CNT_LO;
        CNT_LO: if (r_bv) begin
          if ({1'b0, w_n_new} > w_max) w_nst = ERROR;
          else if (w_n_new == 16'd0)   w_nst = W_END;
          else                         w_nst = WORD;
        end
        // Leave only after the final strobe so run lags imem_we by a cycle
        WORD: if (r_we && r_widx == r_n[ADDR_W:0]) w_nst = W_END;
`ifdef LOADER_CHECKSUM_EN
        CHK: if (r_bv) w_nst = (w_byte == r_xor) ? DONE : ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n     <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_bv) begin
        case (r_st)
          CNT_HI: r_n[15:8] <= w_byte;
          CNT_LO: begin
            r_n[7:0] <= w_byte;
            r_widx   <= '0;
            r_bidx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor    <= '0;
`endif
          end
          WORD: begin
            r_asm <= {r_asm[23:0], w_byte};
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ w_byte;
`endif
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {r_asm[23:0], w_byte};
              r_addr  <= 32'(r_widx[ADDR_W-1:0]) << 2;
              r_widx  <= r_widx + 1'b1;
              r_bidx  <= '0;
            end else r_bidx <= r_bidx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.busy  = 1'b0;
    bus.run   = 1'b0;
    bus.error = 1'b0;
    unique case (r_st)
      CNT_LO, WORD, CHK: bus.busy = 1'b1;
      DONE:              bus.run   = 1'b1;
      ERROR:             bus.error = 1'b1;
      default: ;
    endcase
    // A bad stop bit shows as error one cycle before the FSM lands in ERROR
    if (r_ferr && w_live) begin
      bus.busy  = 1'b0;
      bus.error = 1'b1;
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader in front of the MIPS datapath. It receives a program image over the serial `rx` line using an internal 16x-oversampled 8N1 UART receiver. It assembles the bytes into 32-bit instructions and writes them into instruction memory at sequential word addresses. When the image is complete it raises `run` to release the pipeline's PC.

## Interface
- `BAUD_DIV`, 27: clock cycles per oversample tick (one bit = 16 ticks). 27 gives ≈115200 baud at 50 MHz. Must be ≥1.
- `ADDR_W`, 10: word-address width. Maximum image is 2^ADDR_W words.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out 32: byte address, always word-aligned (`word_index*4`). Upper bits are zero.
- `imem_wdata` out 32: instruction word.
- `busy` out 1: image load in progress.
- `run` out 1: image loaded; the datapath may fetch. Sticky.
- `error` out 1: load aborted. Sticky.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer before any use.
- **UART receiver:**
  - Tick counter divides by `BAUD_DIV`.
  - In RX_IDLE, a synchronized low starts a new frame.
  - At tick 7 the start bit is re-sampled. If high, it is a false start and the receiver returns to RX_IDLE with no byte.
  - After that, one sample is taken every 16 ticks: 8 data bits (LSB first), then the stop bit.
  - Stop bit high produces a one-cycle `byte_valid`.
  - Stop bit low is a framing error. The byte is discarded and the loader goes to ERROR.
  - The receiver returns to RX_IDLE right after the stop-bit sample.
- **Image format:** `N_hi`, `N_lo` (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first. With `LOADER_CHECKSUM_EN`, one trailing checksum byte follows.
- **Loader FSM states:** CNT_HI, CNT_LO, WORD, CHK, DONE, ERROR.
- **CNT_HI:** on a byte, store `N[15:8]`, set `busy`, go to CNT_LO.
- **CNT_LO:** on a byte, store `N[7:0]`.
  - If N > 2^ADDR_W, go to ERROR.
  - If N = 0, go to CHK if the checksum is enabled, otherwise DONE.
  - Otherwise go to WORD with byte index 0 and word index 0.
- **WORD:** shift each byte into a 32-bit assembly register.
  - On byte index 3, drive `imem_wdata` (assembled word), `imem_addr = word_index<<2` and `imem_we=1` for exactly one cycle.
  - Then increment the word index and clear the byte index.
  - After word N−1 is written, go to CHK or DONE.
- **DONE:** `run=1`, `busy=0`. All further `rx` traffic is ignored. Exit only by reset.
- **ERROR:** `error=1`, `busy=0`, `run=0`. All further traffic is ignored. Exit only by reset.
- **Width rules:**
  - Word index is ADDR_W+1 bits.
  - The N > 2^ADDR_W comparison is done at 17 bits; no truncation.
  - The largest legal N (2^ADDR_W) writes addresses 0 through (2^ADDR_W−1)*4 with no wrap.

## Timing
- **Reset values:** `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `busy=0`, `run=0`, `error=0`. FSM in CNT_HI, receiver in RX_IDLE.
- **Reset mid-load:** a partial word is lost. Memory contents already written are not cleared.
- **Byte-to-strobe latency:** `byte_valid` fires 1 cycle after the stop-bit sample. For the 4th byte of a word, `imem_we` asserts on the next cycle (registered). `imem_addr` and `imem_wdata` are valid in the same cycle as `imem_we` and hold until the next write.
- **run:** asserts the cycle after the final `imem_we`, or after the cycle that accepts the checksum/N_lo byte when no word is written.
- **error:** asserts the cycle after the offending byte or stop sample.
- **Inter-byte gap:** bytes may arrive back-to-back or with any idle gap; there is no timeout.
- **Simultaneous events:** a new start edge during the stop-bit sample cycle is not detected until the following cycle.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - The loader keeps an 8-bit running XOR of every byte after `N_lo`; the count bytes are excluded.
  - CHK compares the received byte with the running XOR. A match goes to DONE; a mismatch goes to ERROR.
  - Words already written stay in memory, but `run` never asserts on a mismatch.
- **Undefined:** the CHK state and XOR register are absent, and the loader goes to DONE directly after the last word.

## Test plan
Bench uses `BAUD_DIV=1`, `ADDR_W=4`.
- Send 00 02 20 08 00 05 AC 01 00 04 → two `imem_we` pulses: addr 0 data 0x20080005, then addr 4 data 0xAC010004. `run`=1 one cycle after the second pulse; `busy` falls at the same time.
- Send 00 10 plus 16 words → 16 writes, last at addr 0x3C, `run`=1. Send 00 11 instead → `error`=1 after N_lo, no writes.
- Send 00 00 (checksum disabled) → `run`=1 with no `imem_we`. Later bytes produce no response.
- Low glitch on `rx` of 4 ticks, then 00 01 11 22 33 44 → glitch rejected; one write: addr 0 data 0x11223344.
- Stop bit forced low on the 3rd byte → `error`=1, no write, `run` stays 0. Assert `reset` mid-word → all outputs return to 0, and a fresh 00 01 … image then loads normally.
- With `LOADER_CHECKSUM_EN`, send 00 01 11 22 33 44 44 → `run`=1 (0x11^0x22^0x33^0x44 = 0x44). Trailing byte 0x45 instead → `error`=1, `run`=0.
